// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, arbiter FSM encoding, index-width helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

  // Data bits per UART frame; uart_tx, uart_rx and the arbiter must agree.
  localparam int UART_DBIT = 8;

  // Transmit arbiter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } arb_state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin finder: first set request bit at or after ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int W     = owner_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic             found,
  output logic [W-1:0]     idx
);

  int cand;

  // Scan ptr, ptr+1, ... with wrap; the first hit wins and later hits are ignored.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!found && req[W'(cand)]) begin
        found = 1'b1;
        idx   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between N_REQ byte streams: round-robin grant, packet lock until last byte or lock timeout.
// Latency: req_valid in IDLE -> req_ready +1 cycle -> tx_start +2; within a packet tx_done_tick -> tx_start +2.
// Backpressure: req_ready is a one-hot strobe in LOAD only; losers and the owner between bytes hold valid/data/last.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int DBIT         = UART_DBIT,
  parameter  int LOCK_TIMEOUT = 65535,
  localparam int OW           = owner_w(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DBIT-1:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  tx_start,
  output logic [DBIT-1:0]       tx_din,
  input  logic                  tx_done_tick,
  output logic [OW-1:0]         owner,
  output logic                  busy,
  output logic                  timeout_tick
);

  // Timer only has to reach LOCK_TIMEOUT-1.
  localparam int TW = owner_w(LOCK_TIMEOUT);

  arb_state_t      state_q, state_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            locked_q, locked_d;
  logic            last_q, last_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            pick_found;
  logic [OW-1:0]   pick_idx;
  logic [OW-1:0]   owner_nxt;
  logic            own_vld;
  logic            own_last;
  logic [DBIT-1:0] own_dat;
  logic [DBIT-1:0] req_byte [N_REQ];

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Split the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_byte[i] = req_data[i*DBIT +: DBIT];
    end
  end

  // Current owner's request view, and the requester after the owner for rotation.
  always_comb begin
    own_vld   = req_valid[owner_q];
    own_last  = req_last[owner_q];
    own_dat   = req_byte[owner_q];
    owner_nxt = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
  end

  // Next-state and Moore/Mealy outputs; everything holds unless a branch changes it.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    locked_d     = locked_q;
    last_d       = last_q;
    tx_din_d     = tx_din_q;
    timer_d      = timer_q;
    req_ready    = '0;
    tx_start     = 1'b0;
    timeout_tick = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          timer_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        req_ready[owner_q] = 1'b1;
        if (own_vld) begin
          tx_din_d = own_dat;
          last_d   = own_last;
          locked_d = 1'b1;
          state_d  = START;
        end else if (!locked_q) begin
          // Grant evaporated before any byte moved; rescan from the same pointer.
          state_d = IDLE;
        end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
          // Owner went quiet mid-packet for too long; revoke and move on.
          timeout_tick = 1'b1;
          locked_d     = 1'b0;
          rr_ptr_d     = owner_nxt;
          state_d      = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      START: begin
        tx_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (tx_done_tick) begin
          if (last_q) begin
            locked_d = 1'b0;
            rr_ptr_d = owner_nxt;
            state_d  = IDLE;
          end else begin
            timer_d = '0;
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a reset mid-frame simply drops the byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      last_q   <= 1'b0;
      tx_din_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      tx_din_q <= tx_din_d;
      timer_q  <= timer_d;
    end
  end

  assign tx_din = tx_din_q;
  assign owner  = owner_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with requester models, a uart_tx tick model and a byte scoreboard.
// Latency: checks grant/start timing, back-to-back packet timing and lock timeout timing.
// Backpressure: requesters hold valid/data/last until a valid&ready transfer.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N     = 4;
  localparam int DB    = 8;
  localparam int LT    = 16;
  localparam int FRAME = 6;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] dat;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DB-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [DB-1:0]   tx_din;
  logic            tx_done_tick;
  logic [1:0]      owner;
  logic            busy;
  logic            timeout_tick;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .DBIT         (DB),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .owner        (owner),
    .busy         (busy),
    .timeout_tick (timeout_tick)
  );

  exp_t       sb[$];
  logic [8:0] src_q[N][$];
  logic [N-1:0] acc;
  int n_chk, n_pass;
  int cyc_n, tick_left, ticks_seen, last_tick_cyc, tmo_seen, starts_seen;
  logic prev_start, stray;
  logic [7:0] cur_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic send(input int req, input logic [7:0] d, input logic last);
    src_q[req].push_back({last, d});
  endtask

  task automatic expect_tx(input logic [1:0] own, input logic [7:0] d);
    exp_t e;
    e.own = own;
    e.dat = d;
    sb.push_back(e);
  endtask

  // One clock: observe at the falling edge, then drive the tick model and requesters.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    if (tx_start === 1'b1) begin
      starts_seen++;
      check("start_gap", 32'(prev_start), 32'(1'b0));
      check("start_expected", 32'(sb.size() > 0), 32'(1'b1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("owner", 32'(owner), 32'(e.own));
        check("tx_din", 32'(tx_din), 32'(e.dat));
      end
      cur_din = tx_din;
    end
    prev_start = tx_start;
    if (req_ready !== '0) check("ready_onehot", 32'($onehot(req_ready)), 32'(1'b1));
    if (timeout_tick === 1'b1) tmo_seen++;

    tx_done_tick = stray;
    if (reset) begin
      tick_left = 0;
    end else if (tick_left > 0) begin
      tick_left--;
      if (tick_left == 0) begin
        check("din_stable", 32'(tx_din), 32'(cur_din));
        tx_done_tick  = 1'b1;
        ticks_seen++;
        last_tick_cyc = cyc_n;
      end
    end else if (tx_start === 1'b1) begin
      tick_left = FRAME;
    end

    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(src_q[i].pop_front());
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && src_q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_data[i*DB +: DB]  = src_q[i][0][7:0];
        req_last[i]           = src_q[i][0][8];
      end
      acc[i] = !reset && req_valid[i] && (req_ready[i] === 1'b1);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(busy === 1'b0 && sb.size() == 0 && tick_left == 0 && srcs_empty()) && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_done"}, 32'(n < budget), 32'(1'b1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(1'b0));
    check({tag, "_ready"}, 32'(req_ready), 32'(4'b0000));
    check({tag, "_start"}, 32'(tx_start), 32'(1'b0));
    check({tag, "_din"}, 32'(tx_din), 32'(8'h00));
    check({tag, "_owner"}, 32'(owner), 32'(2'd0));
    check({tag, "_tmo"}, 32'(timeout_tick), 32'(1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, s0, t0;
    bit seen;
    n_chk = 0; n_pass = 0; cyc_n = 0; tick_left = 0; ticks_seen = 0;
    last_tick_cyc = 0; tmo_seen = 0; starts_seen = 0;
    prev_start = 1'b0; stray = 1'b0; cur_din = 8'h00; acc = '0;
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done_tick = 1'b0;

    // Reset state
    cyc(); cyc();
    check_reset_outputs("reset");
    check("reset_rr_ptr", 32'(dut.rr_ptr_q), 32'(2'd0));
    reset = 1'b0;
    cyc();

    // Single request, single-byte packet
    send(0, 8'h55, 1'b1);
    expect_tx(2'd0, 8'h55);
    cyc();
    check("single_ready_c0", 32'(req_ready), 32'(4'b0000));
    cyc();
    check("single_ready_c1", 32'(req_ready), 32'(4'b0001));
    cyc();
    check("single_start_c2", 32'(tx_start), 32'(1'b1));
    check("single_din_c2", 32'(tx_din), 32'(8'h55));
    wait_idle("single", 100);
    check("single_busy", 32'(busy), 32'(1'b0));
    check("single_rr_ptr", 32'(dut.rr_ptr_q), 32'(2'd1));

    // Contention: four single-byte packets, then a second round from req0
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
    send(0, 8'h10, 1'b1); send(0, 8'h20, 1'b1);
    send(1, 8'h11, 1'b1); send(2, 8'h12, 1'b1); send(3, 8'h13, 1'b1);
    expect_tx(2'd0, 8'h10); expect_tx(2'd1, 8'h11); expect_tx(2'd2, 8'h12);
    expect_tx(2'd3, 8'h13); expect_tx(2'd0, 8'h20);
    wait_idle("contend", 400);

    // Packet lock: req1 three-byte packet while req2 waits
    send(1, 8'hA0, 1'b0); send(1, 8'hA1, 1'b0); send(1, 8'hA2, 1'b1);
    send(2, 8'hBB, 1'b1);
    expect_tx(2'd1, 8'hA0); expect_tx(2'd1, 8'hA1); expect_tx(2'd1, 8'hA2);
    expect_tx(2'd2, 8'hBB);
    base = ticks_seen; seen = 1'b0; n = 0;
    while (sb.size() != 0 && n < 400) begin
      cyc();
      n++;
      if (req_ready[2] === 1'b1 && !seen) begin
        seen = 1'b1;
        check("lock_req2_after_last", 32'(ticks_seen - base), 32'(3));
      end
      if (tx_start === 1'b1 && (sb.size() == 1 || sb.size() == 2)) begin
        check("lock_b2b_latency", 32'(cyc_n - last_tick_cyc), 32'(2));
      end
    end
    wait_idle("lock", 200);

    // Lock timeout: req3 stalls mid-packet while req0 waits
    send(3, 8'h31, 1'b0);
    send(0, 8'h42, 1'b1);
    expect_tx(2'd3, 8'h31); expect_tx(2'd0, 8'h42);
    base = tmo_seen; seen = 1'b0; n = 0;
    while (sb.size() != 0 && n < 400) begin
      cyc();
      n++;
      if (timeout_tick === 1'b1) begin
        check("tmo_timing", 32'(cyc_n - last_tick_cyc), 32'(LT));
      end
      if (req_ready[0] === 1'b1 && !seen) begin
        seen = 1'b1;
        check("tmo_before_req0", 32'(tmo_seen - base), 32'(1));
      end
    end
    wait_idle("tmo", 200);
    check("tmo_count", 32'(tmo_seen - base), 32'(1));

    // Reset during WAIT, then a stale tick
    send(1, 8'h77, 1'b1);
    expect_tx(2'd1, 8'h77);
    s0 = starts_seen; n = 0;
    while (starts_seen == s0 && n < 50) begin
      cyc();
      n++;
    end
    cyc(); cyc();
    check("rstwait_busy", 32'(busy), 32'(1'b1));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_reset_outputs("rstwait");
    stray = 1'b1; cyc(); stray = 1'b0;
    t0 = starts_seen;
    for (int i = 0; i < 10; i++) cyc();
    check("rstwait_no_start", 32'(starts_seen - t0), 32'(0));
    check("rstwait_idle", 32'(busy), 32'(1'b0));

    // Stray tick in IDLE, then in LOAD
    stray = 1'b1; cyc(); stray = 1'b0;
    cyc();
    check("stray_idle_busy", 32'(busy), 32'(1'b0));
    check("stray_idle_ready", 32'(req_ready), 32'(4'b0000));
    send(2, 8'h99, 1'b1);
    expect_tx(2'd2, 8'h99);
    cyc();
    stray = 1'b1;
    cyc();
    check("stray_load_ready", 32'(req_ready), 32'(4'b0100));
    stray = 1'b0;
    cyc();
    check("stray_load_start", 32'(tx_start), 32'(1'b1));
    check("stray_load_din", 32'(tx_din), 32'(8'h99));
    wait_idle("stray", 100);
    check("final_sb_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter (8N1, tick-driven by baud_gen) between N_REQ byte-stream requesters.
- Round-robin arbitration with packet locking: the owner keeps the transmitter until it sends a byte flagged last, or until its lock times out.
- Sits between the client blocks (command responder, debug printer, etc.) and uart_tx.
- Issues tx_start/din pulses and sequences on tx_done_tick.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DBIT, 8, data bits per UART frame; must match uart_tx.
- LOCK_TIMEOUT, 65535, clk cycles a locked owner may leave req_valid low between bytes before the lock is revoked.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester byte available.
- req_data  in  N_REQ*DBIT  per-requester byte; requester i uses bits [i*DBIT +: DBIT].
- req_last  in  N_REQ  byte is final of the packet; sampled with the data.
- req_ready  out  N_REQ  one-hot accept strobe; transfer occurs when req_valid[i] & req_ready[i].
- tx_start  out  1  one-cycle start pulse to uart_tx.
- tx_din  out  DBIT  byte to uart_tx; stable from tx_start until tx_done_tick.
- tx_done_tick  in  1  uart_tx end-of-stop-bit pulse.
- owner  out  $clog2(N_REQ)  index of current/last granted requester.
- busy  out  1  high in any state but IDLE.
- timeout_tick  out  1  one-cycle pulse when a lock is revoked.

Behaviour:
- Reset (synchronous): state=IDLE, rr_ptr=0, owner=0, locked=0, tx_start=0, tx_din=0, req_ready=0, timeout_tick=0, timer=0. Reset mid-frame abandons the byte; uart_tx shares the same reset.
- IDLE:
  - If |req_valid, winner = first set bit scanning rr_ptr, rr_ptr+1, ... with wrap mod N_REQ.
  - Register owner<=winner, then go to LOAD. No valid means stay.
- LOAD:
  - req_ready[owner]=1 (Moore, only in LOAD).
  - If req_valid[owner]: tx_din<=req_data[owner], last_r<=req_last[owner], locked<=1, go to START.
  - Else if !locked: go to IDLE (rr_ptr unchanged).
  - Else timer increments. When timer==LOCK_TIMEOUT-1: timeout_tick=1, locked=0, rr_ptr<=(owner+1) mod N_REQ, go to IDLE.
  - timer clears on entering LOAD.
- START: tx_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold tx_din and wait for tx_done_tick.
  - On tick with last_r=1: locked<=0, rr_ptr<=(owner+1) mod N_REQ, go to IDLE.
  - On tick with last_r=0: go to LOAD (same owner).
- tx_done_tick outside WAIT is ignored.
- Latency: req_valid rises in IDLE at cycle 0 -> req_ready cycle 1 -> tx_start cycle 2. Back-to-back bytes within a packet: tx_done_tick at cycle t -> req_ready t+1 -> tx_start t+2.
- Simultaneous requests: only the rr winner is served. Others see req_ready=0 and must hold valid/data/last stable until accepted.
- Requests arriving during WAIT do not pre-empt a locked owner.
- Single-byte packet: req_last=1 on the first byte gives immediate rotation.
- rr_ptr wrap: owner N_REQ-1 -> rr_ptr 0.
- Exactly one req_ready bit high at most. tx_start is never high in two consecutive cycles.

Decomposition:
- uart_pkg (shared with uart_rx/uart_tx/baud_gen users):
  - DBIT default constant.
  - typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} arb_state_t.
  - clog2-based owner width helper.
- Sub-module rr_pick: combinational round-robin finder with inputs req[N_REQ] and ptr, outputs found and idx. Instantiated once.
- Timer and FSM stay in uart_tx_arbiter.

Test Plan:
- Single request: req_valid=0001, data 0x55, last=1 -> req_ready[0] one cycle, tx_start 2 cycles after valid, tx_din=0x55; after tx_done_tick busy=0 and rr_ptr=1.
- Contention: all four valid, single-byte packets 0x10,0x11,0x12,0x13 held -> bytes sent in order req0,1,2,3; a second round starts at req0; owner sequence 0,1,2,3,0.
- Packet lock: req1 sends 0xA0,0xA1,0xA2 (last on 0xA2) while req2 holds 0xBB -> three req1 bytes back-to-back, then 0xBB; no req2 ready before the last tick.
- Timeout: req3 sends 0x31 (last=0), then drops valid for LOCK_TIMEOUT cycles (override 16) while req0 waits -> timeout_tick pulses once, next grant is owner=0.
- Reset mid-WAIT: assert reset one cycle during WAIT -> next cycle state IDLE, all outputs at reset values, stale tx_done_tick afterwards causes no tx_start.
- Stray tick: tx_done_tick pulsed in IDLE and LOAD -> no state change and no req_ready glitch.
